rbcp_master: RTL and testbench
==============================

// Module: rbcp_master
// PURPOSE
//  Initiator side of the 8-bit RBCP register bus: turns single read/write commands into RBCP strobes
//  and returns the ack'd read byte or a timeout. Drives the register slaves (data-number/channel/trigger
//  block) from an on-chip sequencer or debug bridge, in place of the SiTCP core.
// PARAMETERS
//  ADDR_W          32   RBCP address width
//  TIMEOUT_CYCLES  255  max WAIT cycles without ack before abort (>=1)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous active-high reset
//  cmd_valid    in   1       command offered
//  cmd_ready    out  1       command accepted when valid&ready
//  cmd_write    in   1       1=write, 0=read (rbcp_pkg::rbcp_op_e)
//  cmd_addr     in   ADDR_W  target register address
//  cmd_wdata    in   8       write byte (ignored for reads)
//  rsp_valid    out  1       response available, held until rsp_ready
//  rsp_ready    in   1       response consumed
//  rsp_rdata    out  8       read byte; 0 for writes and timeouts
//  rsp_timeout  out  1       1 = no ack within TIMEOUT_CYCLES
//  rbcp_act     out  1       transaction active
//  rbcp_addr    out  ADDR_W  bus address, stable while rbcp_act
//  rbcp_we      out  1       one-cycle write strobe
//  rbcp_re      out  1       one-cycle read strobe
//  rbcp_wd      out  8       write data, stable while rbcp_act
//  rbcp_ack     in   1       one-cycle slave ack; rbcp_rd valid same cycle
//  rbcp_rd      in   8       slave read data
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters cleared; applies mid-transaction (act/strobe drop next cycle,
//    pending response discarded). All outputs registered.
//  - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: cmd_ready=1. On cmd_valid: latch op/addr/wdata, go ISSUE.
//  - ISSUE (1 cycle): rbcp_act=1, exactly one of rbcp_we/rbcp_re=1, addr/wd driven. -> WAIT, counter=0.
//  - WAIT: rbcp_act=1, strobes 0. rbcp_ack=1 -> capture rbcp_rd (reads only), rsp_timeout=0, -> RESP.
//    Else counter++; counter reaching TIMEOUT_CYCLES -> rsp_rdata=0, rsp_timeout=1, -> RESP.
//    Ack on the same cycle counter reaches limit: ack wins.
//  - RESP: rbcp_act=0, rsp_valid=1, data/flag stable; rsp_valid&rsp_ready -> IDLE. No new command
//    accepted until response consumed (one outstanding transaction).
//  - rbcp_ack in IDLE, ISSUE or RESP ignored (spurious).
//  - Latency: cmd handshake at edge k -> strobe in cycle k+1; ack in cycle k+1+n (n>=1) -> rsp_valid
//    in cycle k+2+n. Back-to-back: next cmd_ready the cycle after rsp handshake.
//  - Counter width $clog2(TIMEOUT_CYCLES+1); no wrap possible.
// CONFIGURATION
//  RBCP_MASTER_STATS_EN defined: adds outputs stat_txn[31:0] (completed transactions), stat_timeout[15:0]
//  (timeouts), stat_spurious[15:0] (ignored acks); all saturate at max, cleared by rst.
//  Undefined: ports absent, no counter logic.
// STRUCTURE
//  rbcp_pkg: rbcp_op_e {RBCP_OP_READ=0, RBCP_OP_WRITE=1}, rbcp_master_state_e {IDLE,ISSUE,WAIT,RESP},
//  RBCP_DATA_W=8. Sub-module rbcp_watchdog: clear/enable/expired timeout counter, parameter TIMEOUT_CYCLES.
// TESTING
//  1 write addr=0x4 wd=0xA5, ack 1 cycle after rbcp_we -> single we pulse, addr 0x4, rsp_valid, timeout=0
//  2 read addr=0x0, slave acks after 3 cycles with rd=0x12 -> rsp_rdata=0x12, rsp_valid 1 cycle after ack
//  3 read addr=0x7, TIMEOUT_CYCLES=4, no ack -> rsp_timeout=1, rdata=0, act low after 4 WAIT cycles
//  4 ack coincides with limit cycle, rd=0x3C -> rsp_timeout=0, rdata=0x3C; spurious ack in IDLE ignored
//  5 rsp_ready low 10 cycles -> rsp held stable, cmd_ready=0, no new strobe; released -> next cmd taken
//  6 rst asserted in WAIT -> next cycle act=0, rsp_valid=0, cmd_ready=1 after rst; stats (EN) = 0

Source files
------------

// File: rtl/rbcp_pkg.sv
// Shared types and constants for the RBCP register-bus initiator.
package rbcp_pkg;

    localparam int RBCP_DATA_W = 8;

    typedef enum logic {
        RBCP_OP_READ  = 1'b0,
        RBCP_OP_WRITE = 1'b1
    } rbcp_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } rbcp_master_state_e;

endpackage

// File: rtl/rbcp_watchdog.sv
// Counts WAIT cycles without an ack; flags the cycle in which the limit is reached.
module rbcp_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Fires while counting the final cycle, so the abort lands exactly on the limit.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/rbcp_master.sv
// RBCP initiator: one outstanding read/write, registered outputs, ack timeout.
// Optional statistics counters are built when RBCP_MASTER_STATS_EN is defined.
module rbcp_master
    import rbcp_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [RBCP_DATA_W-1:0] cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [RBCP_DATA_W-1:0] rsp_rdata,
    output logic                   rsp_timeout,
    output logic                   rbcp_act,
    output logic [ADDR_W-1:0]      rbcp_addr,
    output logic                   rbcp_we,
    output logic                   rbcp_re,
    output logic [RBCP_DATA_W-1:0] rbcp_wd,
    input  logic                   rbcp_ack,
    input  logic [RBCP_DATA_W-1:0] rbcp_rd
`ifdef RBCP_MASTER_STATS_EN
    ,
    output logic [31:0]            stat_txn,
    output logic [15:0]            stat_timeout,
    output logic [15:0]            stat_spurious
`endif
);

    rbcp_master_state_e state, state_nxt;
    rbcp_op_e           op, op_nxt;

    logic [ADDR_W-1:0]      addr_nxt;
    logic [RBCP_DATA_W-1:0] wd_nxt;
    logic [RBCP_DATA_W-1:0] rdata_nxt;
    logic                   timeout_nxt;
    logic                   ready_nxt;
    logic                   act_nxt;
    logic                   we_nxt;
    logic                   re_nxt;
    logic                   valid_nxt;
    logic                   wd_expired;

    rbcp_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != WAIT),
        .enable ((state == WAIT) && !rbcp_ack),
        .expired(wd_expired)
    );

    // Every output is derived from the next state so it can be registered with no extra latency.
    always_comb begin
        state_nxt   = state;
        op_nxt      = op;
        addr_nxt    = rbcp_addr;
        wd_nxt      = rbcp_wd;
        rdata_nxt   = rsp_rdata;
        timeout_nxt = rsp_timeout;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_nxt    = rbcp_op_e'(cmd_write);
                    addr_nxt  = cmd_addr;
                    wd_nxt    = cmd_wdata;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (rbcp_ack) begin
                    rdata_nxt   = (op == RBCP_OP_READ) ? rbcp_rd : '0;
                    timeout_nxt = 1'b0;
                    state_nxt   = RESP;
                end else if (wd_expired) begin
                    rdata_nxt   = '0;
                    timeout_nxt = 1'b1;
                    state_nxt   = RESP;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        ready_nxt = (state_nxt == IDLE);
        act_nxt   = (state_nxt == ISSUE) || (state_nxt == WAIT);
        we_nxt    = (state_nxt == ISSUE) && (op_nxt == RBCP_OP_WRITE);
        re_nxt    = (state_nxt == ISSUE) && (op_nxt == RBCP_OP_READ);
        valid_nxt = (state_nxt == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op          <= RBCP_OP_READ;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            rbcp_act    <= 1'b0;
            rbcp_addr   <= '0;
            rbcp_we     <= 1'b0;
            rbcp_re     <= 1'b0;
            rbcp_wd     <= '0;
        end else begin
            state       <= state_nxt;
            op          <= op_nxt;
            cmd_ready   <= ready_nxt;
            rsp_valid   <= valid_nxt;
            rsp_rdata   <= rdata_nxt;
            rsp_timeout <= timeout_nxt;
            rbcp_act    <= act_nxt;
            rbcp_addr   <= addr_nxt;
            rbcp_we     <= we_nxt;
            rbcp_re     <= re_nxt;
            rbcp_wd     <= wd_nxt;
        end
    end

`ifdef RBCP_MASTER_STATS_EN
    // Saturating counters; a transaction counts once its response is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_txn      <= '0;
            stat_timeout  <= '0;
            stat_spurious <= '0;
        end else begin
            if ((state == RESP) && rsp_valid && rsp_ready && (stat_txn != '1)) begin
                stat_txn <= stat_txn + 1'b1;
            end
            if ((state == WAIT) && !rbcp_ack && wd_expired && (stat_timeout != '1)) begin
                stat_timeout <= stat_timeout + 1'b1;
            end
            if ((state != WAIT) && rbcp_ack && (stat_spurious != '1)) begin
                stat_spurious <= stat_spurious + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rbcp_master.sv
// Directed, table-driven bench for rbcp_master built with a short ack timeout.
module tb_rbcp_master;

    localparam int ADDR_W = 32;
    localparam int TO     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [7:0]        cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [7:0]        rsp_rdata;
    logic              rsp_timeout;
    logic              rbcp_act;
    logic [ADDR_W-1:0] rbcp_addr;
    logic              rbcp_we;
    logic              rbcp_re;
    logic [7:0]        rbcp_wd;
    logic              rbcp_ack = 1'b0;
    logic [7:0]        rbcp_rd = '0;
`ifdef RBCP_MASTER_STATS_EN
    logic [31:0]       stat_txn;
    logic [15:0]       stat_timeout;
    logic [15:0]       stat_spurious;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    rbcp_master #(
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .rbcp_act   (rbcp_act),
        .rbcp_addr  (rbcp_addr),
        .rbcp_we    (rbcp_we),
        .rbcp_re    (rbcp_re),
        .rbcp_wd    (rbcp_wd),
        .rbcp_ack   (rbcp_ack),
        .rbcp_rd    (rbcp_rd)
`ifdef RBCP_MASTER_STATS_EN
        ,
        .stat_txn     (stat_txn),
        .stat_timeout (stat_timeout),
        .stat_spurious(stat_spurious)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [7:0]  wdata;
        int          ack_delay;
        logic [7:0]  rd;
        logic [7:0]  exp_rdata;
        logic        exp_timeout;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic sendCmd(input logic write, input logic [31:0] addr, input logic [7:0] wdata);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
        checkOutput("issue_ctrl", {28'd0, rbcp_act, rbcp_we, rbcp_re, cmd_ready},
                    {28'd0, 1'b1, write, !write, 1'b0});
        checkOutput("issue_addr", rbcp_addr, addr);
        if (write) checkOutput("issue_wd", 32'(rbcp_wd), 32'(wdata));
    endtask

    task automatic runWait(input int ack_delay, input logic [7:0] rd,
                           input logic [7:0] exp_rdata, input logic exp_timeout);
        int n_wait;
        n_wait = (ack_delay >= 1 && ack_delay <= TO) ? ack_delay : TO;
        for (int n = 1; n <= n_wait; n++) begin
            tick();
            checkOutput("wait_bus", {28'd0, rbcp_act, rbcp_we, rbcp_re, rsp_valid}, 32'b1000);
            if (n == ack_delay) begin
                rbcp_ack = 1'b1;
                rbcp_rd  = rd;
            end
        end
        tick();
        rbcp_ack = 1'b0;
        rbcp_rd  = '0;
        checkOutput("rsp_ctrl", {29'd0, rsp_valid, rbcp_act, cmd_ready}, 32'b100);
        checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
        checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(exp_timeout));
    endtask

    task automatic consumeRsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("after_rsp", {30'd0, cmd_ready, rsp_valid}, 32'b10);
    endtask

    task automatic applyStimulus(input vec_t v);
        sendCmd(v.write, v.addr, v.wdata);
        runWait(v.ack_delay, v.rd, v.exp_rdata, v.exp_timeout);
        consumeRsp();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0004, 8'hA5, 1, 8'hEE, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0000, 8'h00, 3, 8'h12, 8'h12, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0007, 8'h00, 0, 8'h00, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 32'h0000_0009, 8'h00, TO, 8'h3C, 8'h3C, 1'b0};
        vecs[4] = '{1'b1, 32'h1234_5678, 8'h5A, 2, 8'h44, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0010, 8'h0F, 0, 8'h00, 8'h00, 1'b1};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF, 8'h00, 1, 8'h81, 8'h81, 1'b0};

        // Reset state
        repeat (3) tick();
        checkOutput("reset_outputs",
                    {22'd0, cmd_ready, rsp_valid, rsp_timeout, rbcp_act, rbcp_we, rbcp_re, rsp_rdata == 8'd0,
                     rbcp_addr == '0, rbcp_wd == 8'd0, 1'b0}, 32'b0000_0011_10);
        rst = 1'b0;
        tick();
        checkOutput("ready_after_reset", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Spurious acks while idle
        rbcp_ack = 1'b1;
        rbcp_rd  = 8'h77;
        repeat (2) tick();
        rbcp_ack = 1'b0;
        rbcp_rd  = '0;
        tick();
        checkOutput("idle_spurious", {29'd0, cmd_ready, rsp_valid, rbcp_act}, 32'b100);

        // Response held under backpressure, with a queued command and a spurious ack
        sendCmd(1'b0, 32'h20, 8'h00);
        runWait(1, 8'h5E, 8'h5E, 1'b0);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h30;
        cmd_wdata = 8'hC3;
        for (int i = 0; i < 10; i++) begin
            rbcp_ack = (i == 3);
            rbcp_rd  = (i == 3) ? 8'h99 : 8'h00;
            tick();
            checkOutput("stall_ctrl", {27'd0, rsp_valid, cmd_ready, rbcp_act, rbcp_we, rbcp_re}, 32'b10000);
            checkOutput("stall_data", {23'd0, rsp_timeout, rsp_rdata}, 32'h05E);
        end
        rbcp_ack  = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("stall_release", {30'd0, cmd_ready, rsp_valid}, 32'b10);
        tick();
        cmd_valid = 1'b0;
        checkOutput("queued_issue", {29'd0, rbcp_act, rbcp_we, rbcp_re}, 32'b110);
        checkOutput("queued_addr", rbcp_addr, 32'h30);
        checkOutput("queued_wd", 32'(rbcp_wd), 32'hC3);
        runWait(1, 8'h11, 8'h00, 1'b0);
        consumeRsp();

        // Reset in the middle of WAIT
        sendCmd(1'b0, 32'h40, 8'h00);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        checkOutput("reset_mid_wait", {28'd0, rbcp_act, rsp_valid, rbcp_re, cmd_ready}, 32'b0000);
        rst = 1'b0;
        tick();
        checkOutput("ready_after_mid_reset", {29'd0, cmd_ready, rbcp_act, rsp_valid}, 32'b100);
`ifdef RBCP_MASTER_STATS_EN
        checkOutput("stats_cleared", stat_txn | 32'(stat_timeout) | 32'(stat_spurious), 32'd0);
`endif
        applyStimulus(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
